exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer.sv | 113 +++++++++++
 tb/tb_exec_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: fetches one 16-bit instruction, reads operands,
// hands them to an external ALU, and writes the result back to a 16 x 32 register file.
module exec_sequencer #(
  parameter int COND_EN = 1
) (
  input  logic        CLK,
  input  logic        nReset,
  input  logic [15:0] Instr,
  input  logic        InstrValid,
  output logic        InstrReady,
  output logic [31:0] ScrA,
  output logic [31:0] ScrB,
  output logic        ALUControl,
  output logic [2:0]  InstrCode,
  input  logic [31:0] ALUResult,
  input  logic        ALUFlags,
  output logic        ZFlag,
  output logic        Done,
  output logic        Illegal,
  input  logic [3:0]  DbgAddr,
  output logic [31:0] DbgData,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] instr_q;
  logic [31:0] res_q;
  logic        zero_q;
  logic        skip_q;
  logic [31:0] rf [16];

  logic [2:0] op;
  logic [3:0] rd, rn, rm;
  assign op = instr_q[15:13];
  assign rd = instr_q[11:8];
  assign rn = instr_q[7:4];
  assign rm = instr_q[3:0];

  // Handshake: a transfer happens on a rising edge where InstrValid and InstrReady
  // are both high; InstrReady is high only while idle, so Instr is ignored otherwise.
  assign InstrReady = (state == IDLE);
  assign DbgData    = rf[DbgAddr];
  assign dbg_state  = state;

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      instr_q    <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      skip_q     <= 1'b0;
      ScrA       <= '0;
      ScrB       <= '0;
      ALUControl <= 1'b0;
      InstrCode  <= '0;
      ZFlag      <= 1'b0;
      Done       <= 1'b0;
      Illegal    <= 1'b0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      Done    <= 1'b0;
      Illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (InstrValid) begin
            instr_q <= Instr;
            // Conditional instructions with a clear zero flag retire without executing.
            if ((COND_EN != 0) && Instr[12] && !ZFlag) begin
              skip_q <= 1'b1;
              state  <= WB;
            end else begin
              skip_q <= 1'b0;
              state  <= DECODE;
            end
          end
        end
        DECODE: begin
          ScrA       <= rf[rn];
          ScrB       <= rf[rm];
          InstrCode  <= op;
          ALUControl <= (op == 3'b001) || (op == 3'b011);
          state      <= EXEC;
        end
        EXEC: begin
          res_q  <= ALUResult;
          zero_q <= ALUFlags;
          state  <= WB;
        end
        WB: begin
          Done <= 1'b1;
          if (!skip_q) begin
            if (op[2]) begin
              Illegal <= 1'b1;
            end else begin
              ZFlag <= zero_q;
              if (op != 3'b011) rf[rd] <= res_q;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: drives instructions, models the external ALU,
// and checks retirement timing/Illegal through a scoreboard plus register-file reads.
module tb_exec_sequencer;

  logic        CLK = 1'b0;
  logic        nReset = 1'b0;
  logic [15:0] Instr = '0;
  logic        InstrValid = 1'b0;
  logic        InstrReady;
  logic [31:0] ScrA, ScrB;
  logic        ALUControl;
  logic [2:0]  InstrCode;
  logic [31:0] ALUResult;
  logic        ALUFlags;
  logic        ZFlag, Done, Illegal;
  logic [3:0]  DbgAddr = '0;
  logic [31:0] DbgData;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Entry: {accept cycle[15:0], expected accept-to-Done edges[3:0], expected Illegal}
  logic [20:0] exp_q[$];

  logic        alu_force = 1'b0;
  logic [31:0] alu_val = '0;

  exec_sequencer #(.COND_EN(1)) dut (
    .CLK(CLK), .nReset(nReset), .Instr(Instr), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .ScrA(ScrA), .ScrB(ScrB), .ALUControl(ALUControl),
    .InstrCode(InstrCode), .ALUResult(ALUResult), .ALUFlags(ALUFlags),
    .ZFlag(ZFlag), .Done(Done), .Illegal(Illegal), .DbgAddr(DbgAddr),
    .DbgData(DbgData), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // External ALU model; the force path is how the bench seeds nonzero register values.
  always_comb begin
    if (alu_force) ALUResult = alu_val;
    else if (InstrCode == 3'b010) ALUResult = ScrB;
    else if (ALUControl) ALUResult = ScrA - ScrB;
    else ALUResult = ScrA + ScrB;
    ALUFlags = (ALUResult == 32'd0);
  end

  // Monitor: every Done pulse retires the oldest expected instruction.
  always @(negedge CLK) begin
    if (Done) begin
      logic [20:0] e;
      int lat;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: Done=1 at cycle %0d, required no retirement", cyc);
      end else begin
        e = exp_q.pop_front();
        lat = cyc - int'(e[20:5]);
        if (lat != int'(e[4:1]) || Illegal != e[0]) begin
          errors++;
          $display("FAIL retire: latency=%0d illegal=%0b, required latency=%0d illegal=%0b",
                   lat, Illegal, e[4:1], e[0]);
        end
      end
    end else if (Illegal) begin
      checks++;
      errors++;
      $display("FAIL illegal_alone: Illegal=1 without Done at cycle %0d", cyc);
    end
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_rf(input logic [3:0] idx, input logic [31:0] exp);
    @(negedge CLK);
    DbgAddr = idx;
    #1;
    check_eq($sformatf("rf[%0d]", idx), DbgData, exp);
  endtask

  // Driver: waits for InstrReady, presents one instruction, returns the accept cycle.
  task automatic issue(input logic [15:0] ins, input bit exp_ill, input int exp_lat,
                       input bit frc, input logic [31:0] fval, input bit track,
                       output int acc);
    int n = 0;
    @(negedge CLK);
    while (!InstrReady && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!InstrReady) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: InstrReady=0 after 50 cycles, required 1");
      acc = -1;
      return;
    end
    alu_force  = frc;
    alu_val    = fval;
    Instr      = ins;
    InstrValid = 1'b1;
    @(posedge CLK);
    #1;
    acc = cyc;
    InstrValid = 1'b0;
    Instr = 16'($urandom_range(0, 65535));
    if (track) exp_q.push_back({acc[15:0], exp_lat[3:0], exp_ill});
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while ((exp_q.size() != 0 || !InstrReady) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || !InstrReady) begin
      errors++;
      $display("FAIL idle_timeout: pending=%0d ready=%0b, required 0 pending and ready",
               exp_q.size(), InstrReady);
    end
  endtask

  initial begin
    int a0, a1;
    repeat (3) @(negedge CLK);
    nReset = 1'b1;
    @(negedge CLK);
    check_eq("reset_ready", {31'd0, InstrReady}, 32'd1);
    check_eq("reset_state", {30'd0, dbg_state}, 32'd0);
    check_eq("reset_zflag", {31'd0, ZFlag}, 32'd0);
    check_eq("reset_scra", ScrA, 32'd0);
    check_eq("reset_code", {29'd0, InstrCode}, 32'd0);

    // MOV R1,R0 then ADD R2,R1,R1 back to back
    issue(16'h4100, 1'b0, 3, 1'b0, 32'd0, 1'b1, a0);
    issue(16'h0211, 1'b0, 3, 1'b0, 32'd0, 1'b1, a1);
    check_eq("accept_spacing_exec", a1 - a0, 32'd4);
    wait_idle();
    check_rf(4'd2, 32'd0);
    check_eq("zflag_after_add", {31'd0, ZFlag}, 32'd1);

    // Seed R3=5, R4=7 through the ALU, then SUB R5,R3,R4
    issue(16'h4300, 1'b0, 3, 1'b1, 32'd5, 1'b1, a0);
    issue(16'h4400, 1'b0, 3, 1'b1, 32'd7, 1'b1, a0);
    issue(16'h2534, 1'b0, 3, 1'b0, 32'd0, 1'b1, a0);
    wait_idle();
    check_rf(4'd3, 32'd5);
    check_rf(4'd4, 32'd7);
    check_rf(4'd5, 32'hFFFF_FFFE);
    check_eq("zflag_after_sub", {31'd0, ZFlag}, 32'd0);

    // CMP R3,R3 sets ZFlag without writing; conditional MOV R6,R3 then executes
    issue(16'h6033, 1'b0, 3, 1'b0, 32'd0, 1'b1, a0);
    wait_idle();
    check_eq("zflag_after_cmp", {31'd0, ZFlag}, 32'd1);
    check_rf(4'd0, 32'd0);
    check_rf(4'd3, 32'd5);
    check_rf(4'd5, 32'hFFFF_FFFE);
    issue(16'h5603, 1'b0, 3, 1'b0, 32'd0, 1'b1, a0);
    wait_idle();
    check_rf(4'd6, 32'd5);
    check_eq("zflag_after_mov", {31'd0, ZFlag}, 32'd0);

    // ZFlag=0: conditional ADD R7 is skipped, then illegal opcode 101 right behind it
    issue(16'h1733, 1'b0, 1, 1'b0, 32'd0, 1'b1, a0);
    issue(16'hA333, 1'b1, 3, 1'b1, 32'd0, 1'b1, a1);
    check_eq("accept_spacing_skip", a1 - a0, 32'd2);
    wait_idle();
    check_rf(4'd7, 32'd0);
    check_rf(4'd3, 32'd5);
    check_eq("zflag_after_illegal", {31'd0, ZFlag}, 32'd0);

    // Reset during EXEC of ADD R8,R3,R3 aborts it
    issue(16'h0833, 1'b0, 3, 1'b0, 32'd0, 1'b0, a0);
    @(posedge CLK);
    @(negedge CLK);
    check_eq("state_exec", {30'd0, dbg_state}, 32'd2);
    nReset = 1'b0;
    repeat (2) @(negedge CLK);
    nReset = 1'b1;
    @(negedge CLK);
    check_eq("ready_after_reset", {31'd0, InstrReady}, 32'd1);
    check_eq("done_after_reset", {31'd0, Done}, 32'd0);
    repeat (4) @(negedge CLK);
    check_rf(4'd8, 32'd0);
    check_rf(4'd3, 32'd0);
    check_eq("pending_after_reset", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
